// File: rtl/dlx_mem_pkg.sv
// Shared encodings for the DLX memory responder: FSM states, request source, counter sizing.
package dlx_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ACK  = 2'b10
  } state_t;

  typedef enum logic {
    DLX  = 1'b0,
    HOST = 1'b1
  } src_t;

  localparam int WAIT_STATES_MAX = 15;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/dlx_mem_req_mux.sv
// Request arbitration: DLX owns the RAM unless in_init grants the host port exclusively.
module dlx_mem_req_mux
  import dlx_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              mr,
  input  logic              mw,
  input  logic              in_init,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] din,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              req_valid,
  output logic              req_src,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata
);

  // Only the low word-address bits reach the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W];

  always_comb begin
    req_valid = 1'b0;
    req_src   = DLX;
    req_we    = 1'b0;
    req_addr  = addr[ADDR_W-1:0];
    req_wdata = din;
    if (in_init) begin
      req_valid = host_req;
      req_src   = HOST;
      req_we    = host_we;
      req_addr  = host_addr;
      req_wdata = host_wdata;
    end else begin
      req_valid = mr | mw;
      req_we    = mw;
    end
  end

endmodule

// File: rtl/dlx_mem_responder.sv
// DLX mr/mw/busy memory responder with programmable wait states and a host port under in_init.
// Optional protocol checking is built when DLX_MEM_PROTOCOL_CHECK_EN is defined.
module dlx_mem_responder
  import dlx_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mr,
  input  logic              mw,
  input  logic              in_init,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              proto_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                op_reg, src_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg, dout_q;
  logic                req_valid, req_src, req_we, load;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;

  dlx_mem_req_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req_mux (
    .mr         (mr),
    .mw         (mw),
    .in_init    (in_init),
    .addr       (addr),
    .din        (din),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .req_valid  (req_valid),
    .req_src    (req_src),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: if (req_valid) begin
        load       = 1'b1;
        cnt_next   = CNT_LOAD;
        state_next = WAIT;
      end
      WAIT: if (cnt_reg != '0) cnt_next = cnt_reg - 1'b1;
            else state_next = ACK;
      ACK:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= 1'b0;
      src_reg   <= DLX;
      addr_reg  <= '0;
      wdata_reg <= '0;
      dout_q    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (load) begin
        op_reg    <= req_we;
        src_reg   <= req_src;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      // Only reads refresh the held read value.
      if (state_reg == ACK && !op_reg) dout_q <= ram_rdata;
    end
  end

  assign ram_en    = (state_reg == WAIT) && (cnt_reg == '0);
  assign ram_we    = ram_en & op_reg;
  assign ram_addr  = addr_reg;
  assign ram_wdata = wdata_reg;
  assign host_ack  = (state_reg == ACK) && (src_reg == HOST);
  assign busy      = (mr | mw) & ~((state_reg == ACK) && (src_reg == DLX));
  assign dout      = (state_reg == ACK) ? ram_rdata : dout_q;

`ifdef DLX_MEM_PROTOCOL_CHECK_EN
  logic proto_err_reg, in_init_d_reg, violation;

  always_comb begin
    violation = mr & mw;
    if (state_reg == WAIT && src_reg == DLX)
      violation = violation | ~(mr | mw) | (in_init & ~in_init_d_reg);
    if (state_reg == WAIT && src_reg == HOST)
      violation = violation | ~host_req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err_reg <= 1'b0;
      in_init_d_reg <= 1'b0;
    end else begin
      in_init_d_reg <= in_init;
      if (violation) proto_err_reg <= 1'b1;
    end
  end

  assign proto_err = proto_err_reg;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_dlx_mem_responder.sv
// Scoreboard bench for dlx_mem_responder: DLX reads/writes, STORE->FETCH, host port, reset mid-op, proto flag.
module tb_dlx_mem_responder;

  localparam int WS  = 1;
  localparam int LAT = WS + 2;
`ifdef DLX_MEM_PROTOCOL_CHECK_EN
  localparam logic PROTO_EXP = 1'b1;
`else
  localparam logic PROTO_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, mr, mw, in_init, host_req, host_we;
  logic [31:0] addr, din, dout, host_wdata, ram_wdata, ram_rdata;
  logic [15:0] host_addr, ram_addr;
  logic        busy, host_ack, ram_en, ram_we, proto_err;
  logic        preload;

  logic [31:0] ram_model [0:65535];
  logic [31:0] exp_mem   [0:65535];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  dlx_mem_responder #(.ADDR_W(16), .DATA_W(32), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .reset      (reset),
    .mr         (mr),
    .mw         (mw),
    .in_init    (in_init),
    .addr       (addr),
    .din        (din),
    .dout       (dout),
    .busy       (busy),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .proto_err  (proto_err)
  );

  // Synchronous single-port RAM, read-before-write, one-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      ram_model[16'h0040] <= 32'hDEADBEEF;
    end else if (ram_en) begin
      ram_rdata <= ram_model[ram_addr];
      if (ram_we) ram_model[ram_addr] <= ram_wdata;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic dlx_op(input logic we, input logic [15:0] a, input logic [31:0] d);
    logic [31:0] e;
    @(posedge clk); #1;
    mr = !we; mw = we; addr = {16'hABCD, a}; din = d;
    if (we) exp_mem[a] = d;
    else exp_q.push_back(exp_mem[a]);
    for (int c = 0; c <= LAT; c++) begin
      @(negedge clk);
      check_val("dlx_busy", busy, c != LAT);
      check_val("dlx_ram_en", ram_en, c == LAT - 1);
      check_val("dlx_ram_we", ram_we, (c == LAT - 1) && we);
      if (c == LAT - 1) check_val("dlx_ram_addr", ram_addr, a);
      if (c == LAT && !we) begin
        e = exp_q.pop_front();
        check_val("dlx_rdata", dout, e);
        last_rd = e;
      end
    end
    mr = 1'b0; mw = 1'b0;
    $display("txn dlx %s addr=0x%04h data=0x%08h", we ? "wr" : "rd", a, we ? d : dout);
  endtask

  task automatic host_op(input logic we, input logic [15:0] a, input logic [31:0] d);
    logic [31:0] e;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    if (we) exp_mem[a] = d;
    else exp_q.push_back(exp_mem[a]);
    for (int c = 0; c <= LAT; c++) begin
      @(negedge clk);
      check_val("host_ack", host_ack, c == LAT);
      check_val("host_busy", busy, mr | mw);
      check_val("host_ram_en", ram_en, c == LAT - 1);
      if (c == LAT - 1) check_val("host_ram_addr", ram_addr, a);
      if (c == LAT && !we) begin
        e = exp_q.pop_front();
        check_val("host_rdata", dout, e);
        last_rd = e;
      end
    end
    host_req = 1'b0;
    $display("txn host %s addr=0x%04h data=0x%08h", we ? "wr" : "rd", a, we ? d : dout);
  endtask

  task automatic check_hold();
    @(negedge clk);
    check_val("dout_hold", dout, last_rd);
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1;
    mr = 1'b0; mw = 1'b0; in_init = 1'b0; addr = '0; din = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    last_rd = '0;
    for (int i = 0; i < 65536; i++) exp_mem[i] = '0;
    exp_mem[16'h0040] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; preload = 1'b0;

    @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_ram_en", ram_en, 0);
    check_val("rst_dout", dout, 0);
    check_val("rst_host_ack", host_ack, 0);
    check_val("rst_proto_err", proto_err, 0);

    dlx_op(1'b0, 16'h0040, '0);
    check_hold();

    // STORE immediately followed by FETCH of the same word
    dlx_op(1'b1, 16'h0010, 32'h12345678);
    dlx_op(1'b0, 16'h0010, '0);
    dlx_op(1'b1, 16'h0020, 32'h0BADF00D);
    check_hold();

    // Host port with a DLX read held high that must be ignored
    @(posedge clk); #1;
    in_init = 1'b1; mr = 1'b1; addr = 32'h0000_0040;
    host_op(1'b1, 16'h03FF, 32'hA5A5A5A5);
    host_op(1'b0, 16'h03FF, '0);
    host_op(1'b0, 16'hFFFF, '0);
    @(posedge clk); #1;
    in_init = 1'b0; mr = 1'b0;
    dlx_op(1'b0, 16'h03FF, '0);

    // Reset while a write is still waiting for its strobe
    @(posedge clk); #1;
    mw = 1'b1; addr = 32'h0000_0040; din = 32'hBAD0BAD0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_val("pre_rst_ram_en", ram_en, 0);
    @(negedge clk);
    check_val("mid_rst_busy", busy, 1);
    check_val("mid_rst_ram_en", ram_en, 0);
    check_val("mid_rst_ram_we", ram_we, 0);
    check_val("mid_rst_host_ack", host_ack, 0);
    check_val("mid_rst_dout", dout, 0);
    check_val("mid_rst_ram_addr", ram_addr, 0);
    check_val("mid_rst_ram_wdata", ram_wdata, 0);
    check_val("mid_rst_proto_err", proto_err, 0);
    @(posedge clk); #1;
    reset = 1'b0; mw = 1'b0;
    last_rd = '0;
    check_hold();
    dlx_op(1'b0, 16'h0040, '0);

    // mr and mw together for one cycle: write wins, access completes
    @(posedge clk); #1;
    mr = 1'b1; mw = 1'b1; addr = 32'h0000_0055; din = 32'hC0FFEE00;
    exp_mem[16'h0055] = 32'hC0FFEE00;
    @(posedge clk); #1;
    mr = 1'b0; mw = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      check_val("both_ram_we", ram_we, c == LAT - 1);
    end
    @(negedge clk);
    check_val("proto_err_set", proto_err, PROTO_EXP);
    $display("txn dlx wr(mr&mw) addr=0x0055 data=0xc0ffee00");
    dlx_op(1'b0, 16'h0055, '0);
    check_val("proto_err_sticky", proto_err, PROTO_EXP);

    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check_val("proto_err_cleared", proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dlx_mem_responder.md
# dlx_mem_responder

Memory-side responder for the DLX control state machine's `mr`/`mw`/`busy` handshake. It accepts read and write requests, inserts programmable wait states, drives a single-port synchronous RAM, and releases `busy` in the exact cycle that read data is valid. While the DLX is idle (`in_init` high), a host port (image loader/readback) gets exclusive access to the same RAM.

## Interface
- `ADDR_W`, 16: RAM word-address width; `addr[ADDR_W-1:0]` is used, upper bits ignored.
- `DATA_W`, 32: data width.
- `WAIT_STATES`, 1: extra cycles before the RAM strobe, range 0–15.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `mr` in 1: DLX read request, level, held until `busy` is sampled low.
- `mw` in 1: DLX write request, level.
- `in_init` in 1: DLX idle/halted; grants the host port.
- `addr` in 32: DLX word address.
- `din` in DATA_W: DLX write data.
- `dout` out DATA_W: read data to DLX and host.
- `busy` out 1: `(mr|mw) & ~(state==ACK & src==DLX)`, combinational.
- `host_req` in 1: host request, level.
- `host_we` in 1: host write.
- `host_addr` in ADDR_W: host address.
- `host_wdata` in DATA_W: host write data.
- `host_ack` out 1: one-cycle completion pulse.
- `ram_en` out 1: RAM strobe.
- `ram_we` out 1: RAM write enable, valid with `ram_en`.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM read data, valid 1 cycle after `ram_en`.
- `proto_err` out 1: sticky protocol-error flag, see Configuration.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE, DLX request:
  - Condition: `(mr|mw) & ~in_init`.
  - Latch `addr[ADDR_W-1:0]`, `din`, `op = mw` (write wins if `mr&mw`), `src = DLX`.
  - Load `cnt = WAIT_STATES`, go to WAIT.
- IDLE, host request:
  - Condition: `in_init & host_req`.
  - Latch host fields, `src = HOST`, load `cnt`, go to WAIT.
  - When `in_init` is high, any DLX request is ignored.
- WAIT:
  - If `cnt != 0`: decrement `cnt`.
  - Else: assert `ram_en` (and `ram_we = op`) for one cycle, go to ACK.
- ACK:
  - `dout = ram_rdata` combinationally; register it into `dout_q`.
  - `host_ack = (src==HOST)`.
  - DLX: `busy` low this cycle.
  - Go to IDLE unconditionally.
- Outside ACK, `dout = dout_q`, which holds the last read value. Writes do not update `dout_q`.
- A request still asserted in the cycle after ACK starts a new transaction. This covers STORE→FETCH back-to-back and a host that holds `host_req`.
- Request dropped during WAIT: the access completes. Writes are committed, then the FSM returns to IDLE. No abort.
- `ram_addr`/`ram_wdata` are driven from the latched registers at all times.

## Timing
- Request seen at cycle 0 in IDLE.
- WAIT occupies cycles 1..WAIT_STATES+1; `ram_en` fires in the last WAIT cycle.
- ACK is at cycle WAIT_STATES+2. DLX `busy` is high for cycles 0..WAIT_STATES+1.
- Minimum latency (WAIT_STATES=0): ACK at cycle 2.
- Reset, including mid-operation:
  - State goes to IDLE; `cnt=0`, `dout_q=0`, `ram_en=0`, `ram_we=0`, `host_ack=0`, `proto_err=0`.
  - Latched address/data cleared to 0.
  - `busy` follows `mr|mw` and is high if a request is held.
  - A pending write is discarded if `ram_en` has not yet fired.

## Configuration
- Macro `DLX_MEM_PROTOCOL_CHECK_EN`, when defined, sets `proto_err` (cleared only by reset) on any of:
  - `mr&mw` both high;
  - a DLX request deasserted while in WAIT with `src==DLX`;
  - `in_init` rising while in WAIT with `src==DLX`;
  - `host_req` deasserted while in WAIT with `src==HOST`.
- Without the macro: `proto_err` is tied 0 and no check logic is built. Functional behaviour is otherwise identical.

## Structure
- Package `dlx_mem_pkg` holds:
  - state encoding IDLE=2'b00, WAIT=2'b01, ACK=2'b10;
  - source encoding DLX=1'b0, HOST=1'b1;
  - the WAIT_STATES range limit constant.
- Sub-module `dlx_mem_req_mux`: combinational selection of address/data/op between the DLX and host fields, with the grant rule. The FSM, counter and data registers stay in `dlx_mem_responder`.

## Test plan
- **DLX read, WAIT_STATES=1, RAM[0x0040]=0xDEADBEEF:** `mr=1`, `addr=0x40` at cycle 0 -> `busy` high cycles 0–2, `ram_en` at cycle 2, `busy` low with `dout=0xDEADBEEF` at cycle 3, IDLE at cycle 4.
- **DLX write then immediate read (STORE→FETCH):** `mw=1`, `addr=0x10`, `din=0x12345678` until `busy` drops, then `mr=1`, `addr=0x10` the next cycle -> exactly one `ram_we` pulse, and the read returns 0x12345678 after a second full latency.
- **Host access under `in_init=1`, WAIT_STATES=0:** host write 0xA5A5A5A5 to 0x3FF, then read -> `host_ack` pulses at cycle 2 of each, read `dout=0xA5A5A5A5`. A concurrent `mr=1` is ignored (`busy` stays high, no RAM access with `src=DLX`).
- **Reset in WAIT of a write, WAIT_STATES=3:** reset at cycle 2 -> no `ram_en`, RAM unchanged, all outputs at reset values the next cycle.
- **With `DLX_MEM_PROTOCOL_CHECK_EN`:** drive `mr=mw=1` for one cycle -> write performed and `proto_err=1` persists until reset. Without the macro, the same stimulus leaves `proto_err=0`.
